// File: rtl/mac_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mac_ctrl_pkg
//  Purpose  : Shared sequencer state encoding and MAC tile instruction codes
//  Revision : 1.0 - initial release
// ============================================================================
package mac_ctrl_pkg;

   // Sequencer phases: one kernel load, weight settle wait, execute, drain
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      KLOAD = 3'd1,
      KWAIT = 3'd2,
      EXEC  = 3'd3,
      DRAIN = 3'd4,
      DONE  = 3'd5
   } state_t;

   // 2-bit tile instruction driven into the array west edge
   localparam logic [1:0] INST_NOP   = 2'b00;
   localparam logic [1:0] INST_KLOAD = 2'b01;
   localparam logic [1:0] INST_EXEC  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/valid_skew_line.sv
`default_nettype none
// ============================================================================
//  Module   : valid_skew_line
//  Purpose  : Shift register of single-bit valids with a contiguous run of
//             taps; tap t is the input delayed by FIRST_TAP + t cycles.
//             'empty' covers the input and every stage, so a valid that is
//             still entering the line keeps it non-empty.
//  Revision : 1.0 - initial release
// ============================================================================
module valid_skew_line #(
   parameter int FIRST_TAP = 9,
   parameter int NUM_TAPS  = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                din,
   output logic [NUM_TAPS-1:0] taps,
   output logic                empty
);

   localparam int c_depth = FIRST_TAP + NUM_TAPS - 1;

   // r_sr[k] holds din delayed by k cycles
   logic [c_depth:1] r_sr;
   logic [c_depth:0] w_line;

   assign w_line = {r_sr, din};
   assign empty  = ~|w_line;

   // Advance the line one stage per cycle; reset flushes every stage
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sr <= '0;
      end else begin
         r_sr <= w_line[c_depth-1:0];
      end
   end

   generate
      for (genvar t = 0; t < NUM_TAPS; t++) begin : g_tap
         assign taps[t] = w_line[FIRST_TAP + t];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/mac_array_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mac_array_seq
//  Purpose  : Sequencer for the weight-stationary MAC array. Issues col
//             kernel-load beats, waits col cycles for weights to settle,
//             issues act_len execute beats, then drains the output skew
//             line that produces per-column OFIFO write strobes.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_array_seq #(
   parameter int row     = 8,
   parameter int col     = 8,
   parameter int len_bw  = 8,
   parameter int out_lat = row + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [len_bw-1:0] act_len,
   input  logic              l0_empty,
   output logic              l0_rd,
   output logic [1:0]        inst,
   output logic [col-1:0]    ofifo_wr,
   output logic              busy,
   output logic              done
);

   import mac_ctrl_pkg::*;

   localparam logic [len_bw-1:0] c_col_last = len_bw'(col - 1);

   state_t            r_state;
   state_t            w_next_state;
   logic [len_bw-1:0] r_cnt;
   logic [len_bw-1:0] r_len;
   logic [len_bw-1:0] w_len_last;
   logic [1:0]        r_inst;
   logic [1:0]        w_issue_inst;
   logic              w_accept;
   logic              w_cnt_clr;
   logic              w_cnt_inc;
   logic              w_skew_empty;

   // Only evaluated in EXEC, where the latched length is known non-zero
   assign w_len_last = r_len - len_bw'(1);
   assign inst       = r_inst;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state, L0 read strobe, instruction to issue and status outputs
   always_comb begin
      w_next_state = r_state;
      w_issue_inst = INST_NOP;
      w_accept     = 1'b0;
      w_cnt_clr    = 1'b0;
      w_cnt_inc    = 1'b0;
      l0_rd        = 1'b0;
      busy         = (r_state != IDLE);
      done         = (r_state == DONE);
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_cnt_clr    = 1'b1;
               w_next_state = KLOAD;
            end
         end
         KLOAD: begin
            if (!l0_empty) begin
               l0_rd        = 1'b1;
               w_issue_inst = INST_KLOAD;
               if (r_cnt == c_col_last) begin
                  w_cnt_clr    = 1'b1;
                  w_next_state = KWAIT;
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end
         end
         KWAIT: begin
            if (r_cnt == c_col_last) begin
               w_cnt_clr    = 1'b1;
               w_next_state = (r_len == '0) ? DRAIN : EXEC;
            end else begin
               w_cnt_inc = 1'b1;
            end
         end
         EXEC: begin
            if (!l0_empty) begin
               l0_rd        = 1'b1;
               w_issue_inst = INST_EXEC;
               if (r_cnt == w_len_last) begin
                  w_cnt_clr    = 1'b1;
                  w_next_state = DRAIN;
               end else begin
                  w_cnt_inc = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (w_skew_empty) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            w_next_state = IDLE;
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Beat / wait counter, shared by KLOAD, KWAIT and EXEC
   always_ff @(posedge clk) begin
      if (reset || w_cnt_clr) begin
         r_cnt <= '0;
      end else if (w_cnt_inc) begin
         r_cnt <= r_cnt + len_bw'(1);
      end
   end

   // Job length held for the whole job so act_len may change freely
   always_ff @(posedge clk) begin
      if (reset) begin
         r_len <= '0;
      end else if (w_accept) begin
         r_len <= act_len;
      end
   end

   // Instruction lags l0_rd by one cycle to line up with L0 read data
   always_ff @(posedge clk) begin
      if (reset) begin
         r_inst <= INST_NOP;
      end else begin
         r_inst <= w_issue_inst;
      end
   end

   valid_skew_line #(
      .FIRST_TAP (out_lat),
      .NUM_TAPS  (col)
   ) u_skew (
      .clk   (clk),
      .reset (reset),
      .din   (r_inst[1]),
      .taps  (ofifo_wr),
      .empty (w_skew_empty)
   );

endmodule
`default_nettype wire

// File: tb/tb_mac_array_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_array_seq
//  Purpose  : Scoreboard bench for mac_array_seq (row = col = 4, len_bw = 8).
//             Each job pushes the expected cycle of every l0_rd, inst,
//             ofifo_wr[c] and done event; a negedge monitor pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_array_seq;

   localparam int ROW     = 4;
   localparam int COL     = 4;
   localparam int LBW     = 8;
   localparam int OUT_LAT = 5;     // row + 1

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           start = 1'b0;
   logic [LBW-1:0] act_len = '0;
   logic           l0_empty = 1'b0;
   logic           l0_rd;
   logic [1:0]     inst;
   logic [COL-1:0] ofifo_wr;
   logic           busy;
   logic           done;

   mac_array_seq #(
      .row    (ROW),
      .col    (COL),
      .len_bw (LBW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .act_len  (act_len),
      .l0_empty (l0_empty),
      .l0_rd    (l0_rd),
      .inst     (inst),
      .ofifo_wr (ofifo_wr),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int val;
   } ev_t;

   int  q_rd[$];
   ev_t q_inst[$];
   int  q_wr[COL][$];
   int  q_done[$];
   int  busy_lo = 1;
   int  busy_hi = 0;
   bit  mon_en = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void check(string name, int act, int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: compare every observed output event against the scoreboard
   always @(negedge clk) begin
      ev_t e;
      if (mon_en) begin
         check("busy", int'(busy), int'(cyc >= busy_lo && cyc <= busy_hi));
         if (l0_rd) begin
            if (q_rd.size() == 0) check("l0_rd_unexpected", 1, 0);
            else                  check("l0_rd_cycle", cyc, q_rd.pop_front());
         end
         if (inst != 2'b00) begin
            if (q_inst.size() == 0) begin
               check("inst_unexpected", int'(inst), 0);
            end else begin
               e = q_inst.pop_front();
               check("inst_cycle", cyc, e.cyc);
               check("inst_value", int'(inst), e.val);
            end
         end
         for (int c = 0; c < COL; c++) begin
            if (ofifo_wr[c]) begin
               if (q_wr[c].size() == 0) check($sformatf("ofifo_wr%0d_unexpected", c), 1, 0);
               else                     check($sformatf("ofifo_wr%0d_cycle", c), cyc, q_wr[c].pop_front());
            end
         end
         if (done) begin
            if (q_done.size() == 0) check("done_unexpected", 1, 0);
            else                    check("done_cycle", cyc, q_done.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_scoreboard();
      q_rd.delete();
      q_inst.delete();
      q_done.delete();
      for (int c = 0; c < COL; c++) q_wr[c].delete();
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_l0_rd"},    int'(l0_rd),    0);
      check({tag, "_inst"},     int'(inst),     0);
      check({tag, "_ofifo_wr"}, int'(ofifo_wr), 0);
      check({tag, "_busy"},     int'(busy),     0);
      check({tag, "_done"},     int'(done),     0);
   endtask

   // One job: start in the current cycle s. Without stalls KLOAD reads at
   // s+1..s+4, KWAIT s+5..s+8, EXEC reads from s+9, inst one cycle after
   // each read, ofifo_wr[c] 5+c cycles after each inst=10, done at s+19+n
   // (+ stall cycles), or s+10 when n = 0.
   task automatic run_job(input int n, input int stall_at, input int stall_len,
                          input bit poke, input int reset_off);
      int  s;
      int  done_c;
      int  rc;
      ev_t e;
      s      = cyc;
      done_c = (n == 0) ? s + 10 : s + 19 + n + stall_len;
      for (int i = 0; i < COL; i++) begin
         q_rd.push_back(s + 1 + i);
         e.cyc = s + 2 + i;
         e.val = 1;
         q_inst.push_back(e);
      end
      for (int i = 0; i < n; i++) begin
         rc = s + 9 + i + ((i >= stall_at) ? stall_len : 0);
         q_rd.push_back(rc);
         e.cyc = rc + 1;
         e.val = 2;
         q_inst.push_back(e);
         for (int c = 0; c < COL; c++) q_wr[c].push_back(rc + 1 + OUT_LAT + c);
      end
      q_done.push_back(done_c);
      busy_lo = s + 1;
      busy_hi = done_c;
      act_len = LBW'(n);
      for (int k = s; k <= done_c; k++) begin
         start    = (k == s) || (poke && (k == s + 10 || k == done_c));
         l0_empty = (stall_len > 0) && (k >= s + 9 + stall_at) &&
                    (k < s + 9 + stall_at + stall_len);
         if (k == s + 1) act_len = 8'hA5;
         reset    = (reset_off > 0) && (k == s + reset_off);
         tick();
         if (reset_off > 0 && k == s + reset_off) begin
            reset    = 1'b0;
            start    = 1'b0;
            l0_empty = 1'b0;
            clear_scoreboard();
            busy_lo  = 1;
            busy_hi  = 0;
            check_all_zero("mid_reset");
            return;
         end
      end
      start    = 1'b0;
      l0_empty = 1'b0;
      check("rd_missing",   q_rd.size(),   0);
      check("inst_missing", q_inst.size(), 0);
      check("done_missing", q_done.size(), 0);
      for (int c = 0; c < COL; c++) check($sformatf("ofifo_wr%0d_missing", c), q_wr[c].size(), 0);
   endtask

   initial begin
      reset = 1'b1;
      repeat (3) tick();
      check_all_zero("reset");
      reset  = 1'b0;
      mon_en = 1'b1;
      repeat (2) tick();

      // Plain job, act_len = 3
      run_job(3, 0, 0, 1'b0, 0);
      repeat (3) tick();

      // Two-cycle L0 stall after the first execute beat
      run_job(3, 1, 2, 1'b0, 0);
      repeat (3) tick();

      // Zero-length job: kernel load and wait only
      run_job(0, 0, 0, 1'b0, 0);
      repeat (3) tick();

      // start during EXEC and during done ignored; next cycle after done accepted
      run_job(3, 0, 0, 1'b1, 0);
      run_job(2, 0, 0, 1'b0, 0);
      repeat (3) tick();

      // Reset in the middle of EXEC, then a normal job
      run_job(3, 0, 0, 1'b0, 11);
      repeat (2) tick();
      run_job(3, 0, 0, 1'b0, 0);
      repeat (3) tick();

      // Maximum length job
      run_job(255, 0, 0, 1'b0, 0);
      repeat (3) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1);
   end

endmodule
`default_nettype wire
